// File: rtl/seven_segment_scan_ctrl.sv
// Frame-synchronous scan controller for a common-anode multi-digit seven-segment display.
// Optional macro SEVSEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits above digit 0.
module seven_segment_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  we_i,
  input  logic [31:0]           data_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o,
  output logic [3:0]            digit_o,
  output logic [2:0]            digit_idx_o
);

  localparam int TICK_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(REFRESH_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);
  localparam logic [2:0]        IDX_LAST   = 3'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           pend_q, pend_d;
  logic [31:0]           disp_q, disp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            digit_q, digit_d;
  logic [2:0]            digit_idx_q, digit_idx_d;
  logic [3:0]            cur_nib_s;
  logic                  lead_zero_s;

  // Slot/frame counters, shadow capture and frame-boundary commit
  always_comb begin
    tick_d = tick_q;
    idx_d  = idx_q;
    disp_d = disp_q;
    if (we_i) begin
      pend_d = data_i;
    end else begin
      pend_d = pend_q;
    end
    if (!enable_i) begin
      tick_d = '0;
      idx_d  = 3'd0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = 3'd0;
        // a write landing on the wrap cycle goes straight to the new frame
        disp_d = we_i ? data_i : pend_q;
      end else begin
        idx_d  = idx_q + 3'd1;
      end
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end
  end

  // Output decode from the current counter state, registered below
  always_comb begin
    cur_nib_s   = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    lead_zero_s = (idx_q != 3'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((3'(k) >= idx_q) && (disp_q[4*k +: 4] != 4'h0)) begin
        lead_zero_s = 1'b0;
      end else begin
        lead_zero_s = lead_zero_s;
      end
    end
`else
    lead_zero_s = 1'b0;
`endif
    an_d        = '1;
    seg_d       = 7'h7F;
    digit_d     = cur_nib_s;
    digit_idx_d = idx_q;
    if (enable_i && (tick_q >= TICK_BLANK) && !lead_zero_s) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (3'(k) != idx_q);
      end
      seg_d = seg_decode(cur_nib_s);
    end else begin
      an_d  = '1;
      seg_d = 7'h7F;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q      <= '0;
      idx_q       <= 3'd0;
      pend_q      <= 32'h0;
      disp_q      <= 32'h0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      digit_q     <= 4'h0;
      digit_idx_q <= 3'd0;
    end else begin
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      digit_q     <= digit_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign digit_o     = digit_q;
  assign digit_idx_o = digit_idx_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench: cycle-level frame model plus directed literal checkpoints.
module tb_seven_segment_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         we = 1'b0;
  logic [31:0]  data = 32'h0;
  logic [N-1:0] an_o;
  logic [6:0]   seg_o;
  logic [3:0]   digit_o;
  logic [2:0]   digit_idx_o;

  int tests = 0;
  int fails = 0;
  int kc = 0;

  seven_segment_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .we_i(we), .data_i(data),
    .an_o(an_o), .seg_o(seg_o), .digit_o(digit_o), .digit_idx_o(digit_idx_o)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: t counts enabled cycles since the scan last restarted
  int          t = 0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] m_disp = 32'h0;
  bit          m_valid = 1'b0;
  logic [N-1:0] exp_an;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_digit;
  logic [2:0]  exp_idx;

  always @(posedge clk) begin
    int  slot;
    int  tick;
    bit  hide;
    logic [3:0] nib;
    if (rst) begin
      exp_an = '1; exp_seg = 7'h7F; exp_digit = 4'h0; exp_idx = 3'd0;
      t = 0; m_pend = 32'h0; m_disp = 32'h0; m_valid = 1'b1;
    end else begin
      slot = (t / R) % N;
      tick = t % R;
      nib  = 4'((m_disp >> (4 * slot)) & 32'hF);
      hide = LZB && (slot > 0) && ((m_disp & ((32'h1 << (4 * N)) - 32'h1)) >> (4 * slot)) == 32'h0;
      exp_idx   = 3'(slot);
      exp_digit = nib;
      if (!en || tick < B || hide) begin
        exp_an = '1; exp_seg = 7'h7F;
      end else begin
        exp_an = ~(N'(1) << slot); exp_seg = dec_tab[nib];
      end
      if (we) m_pend = data;
      if (en && (t % (N * R)) == N * R - 1) m_disp = m_pend;
      t = en ? t + 1 : 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (an_o !== exp_an) begin fails++; $display("FAIL model_an t=%0d: got %b expected %b", t, an_o, exp_an); end
      tests++;
      if (seg_o !== exp_seg) begin fails++; $display("FAIL model_seg t=%0d: got %h expected %h", t, seg_o, exp_seg); end
      tests++;
      if (digit_o !== exp_digit) begin fails++; $display("FAIL model_digit t=%0d: got %h expected %h", t, digit_o, exp_digit); end
      tests++;
      if (digit_idx_o !== exp_idx) begin fails++; $display("FAIL model_idx t=%0d: got %0d expected %0d", t, digit_idx_o, exp_idx); end
    end
  end

  task automatic wait_to(input int k);
    while (kc < k) begin
      @(negedge clk);
      kc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; we = 1'b0; data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    kc = 0;
  endtask

  task automatic write_at(input int k, input logic [31:0] v);
    wait_to(k);
    we = 1'b1; data = v;
    wait_to(k + 1);
    we = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [N-1:0] ean, input logic [6:0] eseg);
    tests++;
    if (an_o !== ean || seg_o !== eseg) begin
      fails++;
      $display("FAIL %s: got an=%b seg=%h expected an=%b seg=%h", name, an_o, seg_o, ean, eseg);
    end
  endtask

  task automatic check_idx(input string name, input logic [2:0] eidx, input logic [3:0] edig);
    tests++;
    if (digit_idx_o !== eidx || digit_o !== edig) begin
      fails++;
      $display("FAIL %s: got idx=%0d digit=%h expected idx=%0d digit=%h", name, digit_idx_o, digit_o, eidx, edig);
    end
  endtask

  initial begin
    // 1: reset release, no writes
    do_reset();
    wait_to(1);  check_lit("t1_blank0", 4'b1111, 7'h7F);
    wait_to(3);  check_lit("t1_drive_d0", 4'b1110, 7'h40);
    wait_to(11); check_lit("t1_drive_d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40);
    wait_to(32); check_idx("t1_idx_last", 3'd3, 4'h0);
    wait_to(33); check_idx("t1_idx_wrap", 3'd0, 4'h0);

    // 2: write lands in the shadow, shown from the next frame
    do_reset();
    write_at(4, 32'h0000_1234);
    wait_to(11); check_lit("t2_old_frame", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40);
    wait_to(35); check_lit("t2_d0", 4'b1110, 7'h19);
    wait_to(43); check_lit("t2_d1", 4'b1101, 7'h30);
    wait_to(51); check_lit("t2_d2", 4'b1011, 7'h24);
    wait_to(59); check_lit("t2_d3", 4'b0111, 7'h79);

    // 3: last write in a frame wins
    do_reset();
    write_at(3, 32'h0000_AAAA);
    write_at(10, 32'h0000_000F);
    wait_to(35); check_lit("t3_d0", 4'b1110, 7'h0E);
    wait_to(43); check_lit("t3_d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40);

    // 4: write on the wrap cycle bypasses into the starting frame
    do_reset();
    write_at(31, 32'h0000_BEEF);
    wait_to(35); check_lit("t4_d0", 4'b1110, 7'h0E);
    wait_to(43); check_lit("t4_d1", 4'b1101, 7'h06);
    wait_to(51); check_lit("t4_d2", 4'b1011, 7'h06);
    wait_to(59); check_lit("t4_d3", 4'b0111, 7'h03);

    // 5: disable mid-slot, re-enable, then reset mid-slot
    do_reset();
    write_at(4, 32'h0000_1234);
    wait_to(51); check_lit("t5_before_dis", 4'b1011, 7'h24);
    en = 1'b0;
    wait_to(52); check_lit("t5_disabled", 4'b1111, 7'h7F);
    wait_to(56); en = 1'b1;
    wait_to(57); check_lit("t5_reen_blank", 4'b1111, 7'h7F);
    wait_to(59); check_lit("t5_reen_d0", 4'b1110, 7'h19);
    wait_to(62); rst = 1'b1;
    wait_to(63); check_lit("t5_rst_out", 4'b1111, 7'h7F);
    check_idx("t5_rst_idx", 3'd0, 4'h0);
    rst = 1'b0;
    wait_to(66); check_lit("t5_after_rst", 4'b1110, 7'h40);

    // 6: value with leading zeros
    do_reset();
    write_at(4, 32'h0000_0030);
    wait_to(35); check_lit("t6_d0", 4'b1110, 7'h40);
    wait_to(43); check_lit("t6_d1", 4'b1101, 7'h30);
    wait_to(51); check_lit("t6_d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40);
    wait_to(59); check_lit("t6_d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40);

    wait_to(64);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display, driven by the processor's memory-mapped display register.
- Captures a 32-bit write into a shadow register.
- Commits the shadow register to the display register only at scan-frame boundaries, so a frame never shows a mix of old and new digits.
- Cycles the active-low anodes digit by digit with a dead-time blank per slot.
- Decodes each nibble internally to active-low segments.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8); digit k shows nibble data[4k+3:4k].
REFRESH_CYCLES, 100000, clock cycles per digit slot (>= 2).
BLANK_CYCLES, 16, dead-time cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_CYCLES).

Ports:
clk_i  input  1  system clock; single clock domain.
rst_i  input  1  synchronous, active-high reset.
enable_i  input  1  scan enable; low blanks the display and holds the scan at its start.
we_i  input  1  write strobe for data_i.
data_i  input  32  display value; nibble k goes to digit k.
an_o  output  NUM_DIGITS  anode selects, active low; at most one bit low.
seg_o  output  7  segments {g,f,e,d,c,b,a}, active low.
digit_o  output  4  nibble currently driven (debug).
digit_idx_o  output  3  index of the current slot (debug).

Behaviour:
- Registers:
  - tick_cnt: 0..REFRESH_CYCLES-1.
  - idx: 0..NUM_DIGITS-1.
  - pend_reg[31:0]: shadow register.
  - disp_reg[31:0]: display register.
- Reset (rst_i high at a clock edge): tick_cnt=0, idx=0, pend_reg=0, disp_reg=0.
  - Outputs: an_o all ones, seg_o=7'h7F, digit_o=0, digit_idx_o=0.
  - Reset mid-slot aborts the slot; the next slot starts at digit 0 in blank phase.
- Writes:
  - we_i high: pend_reg <= data_i. This happens regardless of enable_i.
  - Multiple writes within one frame: the last write wins.
- Counter stepping, each cycle with enable_i high:
  - tick_cnt increments.
  - At REFRESH_CYCLES-1, tick_cnt wraps to 0 and idx increments.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame commit:
  - On the cycle that idx wraps NUM_DIGITS-1 -> 0, disp_reg <= pend_reg.
  - If we_i is high on that same cycle, disp_reg <= data_i directly (bypass); pend_reg is also updated.
  - Frame length is NUM_DIGITS*REFRESH_CYCLES cycles.
- Phases within a slot, decided from the current counter state:
  - BLANK phase (tick_cnt < BLANK_CYCLES): an_o all ones, seg_o=7'h7F.
  - DRIVE phase: an_o[idx]=0 and all other anode bits 1; seg_o=decode(disp_reg[4*idx+3:4*idx]).
- Output timing:
  - an_o, seg_o, digit_o and digit_idx_o are registered: each reflects the counter state of the previous cycle (1-cycle latency).
  - digit_o and digit_idx_o track the slot in both phases.
- enable_i low:
  - tick_cnt and idx are forced to 0.
  - Next registered outputs: an_o all ones, seg_o=7'h7F.
  - disp_reg is not committed.
  - On re-enable, scanning restarts at digit 0 in blank phase.
- Decode table (hex, active low, bit6=g ... bit0=a):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E
- Nibbles above NUM_DIGITS-1 are ignored.

Optional Feature:
Macro: SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - In DRIVE phase, a digit k > 0 is blanked when disp_reg nibbles k..NUM_DIGITS-1 are all zero.
  - A blanked digit drives an_o all ones and seg_o=7'h7F.
  - Digit 0 is always shown, so value 0 displays a single "0".
- Not defined: every digit is always driven, including leading zeros.

Test Plan:
Bench configuration: NUM_DIGITS=4, REFRESH_CYCLES=8, BLANK_CYCLES=2, enable_i=1 unless stated.
1. Reset release, no writes:
   - Registered outputs show 2 blank cycles, then 6 cycles of an_o=4'b1110 with seg_o=7'h40, then digit 1.
   - digit_idx_o wraps 3 -> 0 after 32 cycles.
2. we_i with data_i=32'h0000_1234 in the first frame:
   - First frame still shows all "0" (40).
   - Second frame DRIVE phases: digit0 seg=19 an=1110; digit1 seg=30 an=1101; digit2 seg=24 an=1011; digit3 seg=79 an=0111.
3. Writes 32'hAAAA then 32'h000F in the same frame:
   - Next frame shows F,0,0,0 (0E,40,40,40); value A never appears.
4. we_i of 32'h0000_BEEF exactly on the idx wrap cycle:
   - The starting frame immediately shows F,E,E,B (0E,06,06,03).
5. enable_i low for 5 cycles mid-slot of digit 2:
   - Outputs go blank one cycle later.
   - On re-enable, scan resumes at digit 0 blank phase with disp_reg unchanged.
   - rst_i pulse mid-slot: all outputs return to reset values next cycle and disp_reg reads 0.
6. SEVSEG_LEADING_ZERO_BLANK_EN defined, data 32'h0000_0030:
   - Digits 0 and 1 driven (40, 30); digits 2 and 3 anodes stay high.
   - Data 0: only digit 0 is lit, showing 40.
